// File: rtl/wishbone_ram_responder_if.sv
// Wishbone B4 bus bundle between an initiator and the RAM responder.
// Signal names keep the responder-side _i/_o suffixes of the classic Wishbone pinout.
interface wishbone_ram_responder_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_BYTES    = 1
);
    logic [ADDRESS_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0]    dat_i;
    logic [DATA_WIDTH-1:0]    dat_o;
    logic                     we_i;
    logic [DATA_BYTES-1:0]    sel_i;
    logic                     stb_i;
    logic                     cyc_i;
    logic [2:0]               cti_i;
    logic                     ack_o;
    logic                     err_o;

    modport master (
        output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i,
        input  dat_o, ack_o, err_o
    );

    modport slave (
        input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i,
        output dat_o, ack_o, err_o
    );
endinterface

// File: rtl/wishbone_ram_responder.sv
// Wishbone B4 responder backed by a register-file RAM: classic cycles, incrementing
// bursts, programmable first-beat wait states and ERR outside the address window.
module wishbone_ram_responder_lane #(
    parameter int W = 8
) (
    input  logic [W-1:0] old_q,
    input  logic [W-1:0] wr,
    input  logic         en,
    output logic [W-1:0] merged
);
    assign merged = en ? wr : old_q;
endmodule

module wishbone_ram_responder #(
    parameter int                 ADDRESS_WIDTH = 16,
    parameter int                 DATA_WIDTH    = 8,
    parameter int                 DATA_BYTES    = 1,
    parameter int                 DEPTH_LOG2    = 4,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = '0,
    parameter int                 WAIT_STATES   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    wishbone_ram_responder_if.slave bus
);
    localparam int WORDS  = 1 << DEPTH_LOG2;
    localparam int LANE_W = DATA_WIDTH / DATA_BYTES;
    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_cfg_err
        $error("WAIT_STATES must be in 0..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [WORDS-1:0][DATA_WIDTH-1:0] mem;

    logic                  active, hit, ack_q, err_q, ack, err;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_BYTES-1:0][LANE_W-1:0] cur_word, wr_word, new_word;

    assign active = bus.cyc_i & bus.stb_i;
    assign hit    = bus.adr_i[ADDRESS_WIDTH-1:DEPTH_LOG2] == BASE_ADDRESS[ADDRESS_WIDTH-1:DEPTH_LOG2];
    assign idx    = bus.adr_i[DEPTH_LOG2-1:0];

    // Burst beats are acked without a new decode cycle, so hit is checked live in ACK:
    // a beat that steps out of the window terminates with ERR instead of wrapping.
    assign ack_q = (state == S_ACK) & hit;
    assign err_q = (state == S_ERR) | ((state == S_ACK) & ~hit);
    assign ack   = ack_q & active;
    assign err   = err_q & active;

    assign bus.ack_o = ack;
    assign bus.err_o = err;
    assign bus.dat_o = ack ? mem[idx] : '0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: if (active) begin
                if (!hit)                  state_nxt = S_ERR;
                else if (WAIT_STATES == 0) state_nxt = S_ACK;
                else begin
                    cnt_nxt   = WS4;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!active) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else if (cnt <= 4'd1) begin
                    cnt_nxt   = '0;
                    state_nxt = S_ACK;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_ACK: begin
                if (!active || !hit)          state_nxt = S_IDLE;
                else if (bus.cti_i == 3'b010) state_nxt = S_ACK;
                else                          state_nxt = S_IDLE;
            end
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign cur_word = mem[idx];
    assign wr_word  = bus.dat_i;

    for (genvar k = 0; k < DATA_BYTES; k++) begin : g_lane
        wishbone_ram_responder_lane #(.W(LANE_W)) u_lane (
            .old_q  (cur_word[k]),
            .wr     (wr_word[k]),
            .en     (bus.sel_i[k]),
            .merged (new_word[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)             mem      <= '0;
        else if (ack && bus.we_i) mem[idx] <= new_word;
    end
endmodule

// File: doc/wishbone_ram_responder.md
Name: wishbone_ram_responder

Overview:
Wishbone B4 responder (slave) backed by a small register-file RAM. It is the far end of the bus driven by the block's Wishbone initiator. It answers classic single cycles and incrementing bursts (CTI 010 terminated by 111), with a programmable number of wait states on the first beat and ERR on out-of-window addresses. It gives firmware and the bus master a scratch/mailbox memory and acts as the reference target for initiator verification.

Parameters:
ADDRESS_WIDTH, 16, width of adr_i
DATA_WIDTH, 8, width of dat_i/dat_o
DATA_BYTES, 1, width of sel_i; DATA_WIDTH/DATA_BYTES bits per lane
DEPTH_LOG2, 4, log2 of RAM words (default 16 words)
BASE_ADDRESS, 16'h0000, window base; low DEPTH_LOG2 bits are ignored
WAIT_STATES, 1, extra cycles before the first ack of each cycle; range 0..15

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; asynchronous assert, active-low
adr_i  input  ADDRESS_WIDTH  word address
dat_i  input  DATA_WIDTH  write data
dat_o  output  DATA_WIDTH  read data; valid only while ack_o=1, else 0
we_i  input  1  1=write, 0=read
sel_i  input  DATA_BYTES  byte-lane enables
stb_i  input  1  strobe
cyc_i  input  1  cycle valid
cti_i  input  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst
ack_o  output  1  normal termination
err_o  output  1  error termination; out-of-window address

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_ni=0: FSM=IDLE, wait counter=0, ack_q=err_q=0, all RAM words=0. ack_o, err_o and dat_o read 0.
- hit = (adr_i[ADDRESS_WIDTH-1:DEPTH_LOG2] == BASE_ADDRESS[ADDRESS_WIDTH-1:DEPTH_LOG2]). index = adr_i[DEPTH_LOG2-1:0].
- Outputs are gated: ack_o = ack_q & cyc_i & stb_i; err_o = err_q & cyc_i & stb_i. A master drop always kills the termination in the same cycle.
- Write commit: at the rising edge where ack_o=1 and we_i=1, write lane k of mem[index] from dat_i lane k for each sel_i[k]=1. Lanes with sel_i[k]=0 are unchanged.
- Read data: dat_o = mem[index of current adr_i] combinationally while ack_o=1, else 0. Data is valid in the same cycle as its ack.
- FSM states: IDLE, WAIT, ACK, ERR.
  - IDLE: on cyc_i&stb_i:
    - !hit: go to ERR.
    - WAIT_STATES=0: go to ACK.
    - otherwise: load counter=WAIT_STATES and go to WAIT.
  - WAIT: counter decrements each cycle; at counter=1, go to ACK. If cyc_i=0 or stb_i=0, go to IDLE with no ack and no write.
  - ACK: ack_q=1. Exits, evaluated at each edge:
    - cyc_i=0 or stb_i=0: go to IDLE.
    - cti_i=010: stay in ACK. The next beat is acked with zero wait states at whatever address the master presents; if that address is !hit, go to ERR instead.
    - cti_i=000 or 111: go to IDLE, so ack_q=0 next cycle.
  - ERR: err_q=1 for one cycle, then IDLE. RAM is never written on err.
- Latency: stb_i first high in cycle 0 → first ack_o in cycle WAIT_STATES+1. A classic back-to-back access needs one idle cycle between acks. A burst gives one beat per cycle after the first.
- Wrap: index is taken modulo 2^DEPTH_LOG2. A burst stepping past the window top leaves the window, so that beat gets ERR. There is no silent wrap into word 0.
- Unused cti_i codes (001, 011..110) are treated as 000.
- Reset mid-burst: ack/err clear immediately (asynchronously) and RAM is cleared. After release, the bus sees IDLE and a new cycle starts from the full wait count.
- Wait counter width is 4 bits. A WAIT_STATES value above 15 is a configuration error.

Test Plan:
- Single write then read, WAIT_STATES=1. Write adr=0x0003, dat=0xA5, cti=000 → ack_o high in cycle 2 only, mem[3]=0xA5. Read of 0x0003 → ack in cycle 2 with dat_o=0xA5. dat_o=0 in all other cycles.
- Burst read of 4 words, mem[4..7]=11,22,33,44. Master asserts adr 4 with cti 010, advancing adr on each ack; last beat cti=111. → acks in cycles 2,3,4,5 with dat_o=11,22,33,44, then ack_o=0 in cycle 6.
- Out-of-window access: BASE_ADDRESS=0x0100, access adr=0x0200 → err_o=1 for one cycle, ack_o=0, RAM unchanged. A burst at 0x010E..0x0111 acks 0x010E and 0x010F, then errs on 0x0110.
- Byte lanes: DATA_WIDTH=16, DATA_BYTES=2, mem[1]=0x1234. Write 0xABCD with sel=01 → mem[1]=0x12CD. Write with sel=00 → acked, no change.
- Abort: WAIT_STATES=3, stb_i dropped in cycle 2 → no ack or err ever. The next access still takes 3 wait states.
- Reset mid-burst: rst_ni low after the second burst ack → ack_o=0 in the same cycle and all RAM reads return 0. After release, a new read of adr 0 acks in cycle WAIT_STATES+1 with dat_o=0.
